fht_rom_addr_gen: RTL
=====================

Name: fht_rom_addr_gen

Overview:
- Address sequencer that drives the FHT twiddle ROM block, acting as the initiator for that ROM.
- Per transform, sweeps every stage and every butterfly index, issuing the ROM address and stage-zero flag.
- Emits a valid strobe aligned with the ROM's 1-cycle registered output, so the butterfly datapath consumes sin/cos with no extra alignment logic.
- Sits between the FHT top-level controller (start/done) and the ROM block plus butterfly unit (ready back-pressure).

Parameters:
- A_BIT, 6: ROM address width; butterflies per stage = 2^A_BIT.
- STAGES, 4: number of FHT stages swept per transform; legal range 1..A_BIT+1.
- S_BIT, $clog2(STAGES) (minimum 1): stage counter width; derived, not overridden.

Ports:
- iCLK  in  1  clock.
- iRESET  in  1  asynchronous active-high reset.
- iSTART  in  1  start pulse; sampled only in IDLE.
- iRDY  in  1  datapath ready; address advances only when 1.
- oADDR  out  A_BIT  ROM address, drives ROM iADDR.
- oST_ZERO  out  1  stage-zero flag, drives ROM iST_ZERO; aligned with ROM q (registered alongside valid).
- oSTAGE  out  S_BIT  stage index of the current ROM q.
- oVALID  out  1  ROM q (sin/cos) valid this cycle.
- oBUSY  out  1  high from accepted start until done.
- oDONE  out  1  single-cycle pulse after the last valid.

Behaviour:
- Reset (async, immediate) values: all outputs 0; FSM in IDLE; k = 0; stage = 0.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE -> RUN on iSTART = 1. Sets k = 0, stage = 0, oBUSY = 1.
- RUN, iRDY = 1:
  - Issue the address for (stage, k); the next cycle asserts oVALID with the matching oSTAGE/oST_ZERO.
  - k increments. On k = 2^A_BIT-1, k wraps to 0 and stage increments.
  - On the last address (stage = STAGES-1, k = max), go to FLUSH.
- RUN, iRDY = 0: k and stage hold, oADDR holds; next-cycle oVALID = 0.
  - ROM is re-read at the same address (harmless). Consumer must not count invalid cycles.
- FLUSH: one cycle, delivers the final oVALID; then DONE.
- DONE: oDONE = 1 for one cycle, oBUSY drops; then IDLE.
  - iSTART in DONE is ignored. It is accepted the next cycle in IDLE.
- iSTART in RUN/FLUSH/DONE is ignored; no queuing.
- Address arithmetic: oADDR = k AND MASK(stage).
  - MASK(s) keeps the top s bits of A_BIT and zeroes the rest.
  - s = 0 gives addr 0; s = A_BIT gives the full k.
  - Equivalent to (k >> (A_BIT-s)) << (A_BIT-s). Unsigned, no overflow.
- oST_ZERO = (stage of the registered q == 0).
- Latency: oADDR is combinational from the counters; oVALID/oSTAGE/oST_ZERO are registered one cycle after the address is issued.
- Total valid cycles per transform: exactly STAGES*2^A_BIT (256 at defaults). Minimum start-to-done, with no stalls: 256 + 2 cycles.
- Reset mid-run: aborts immediately to IDLE with all outputs 0. No oDONE.
- iRDY low on the last address: stays in RUN until iRDY = 1, then FLUSH.

Optional Feature:
- Macro: FHT_ROM_ADDR_BITREV_EN.
- Defined: oADDR = bit-reverse(k AND MASK(stage)) over A_BIT bits, for bit-reversed twiddle ROM layouts. The counter sequence is unchanged.
- Undefined: natural order as specified above. No extra logic.

Decomposition:
- Shared package fht_pkg:
  - FSM state encoding (IDLE = 0, RUN = 1, FLUSH = 2, DONE = 3).
  - Mask function.
  - Bit-reverse function.
- One sub-module, fht_addr_cnt: k/stage counter with enable, wrap and last flag. The FSM and output registers live in the top module.

Test Plan:
- Reset/idle: iRESET = 1, then 0, no start -> all outputs 0 for 10 cycles; iRESET asserted mid-cycle clears immediately.
- Full run at defaults, iRDY = 1:
  - oBUSY rises the cycle after iSTART.
  - 256 oVALID pulses; stage 0 all addr 0 with oST_ZERO = 1.
  - Stage 1: addr 0 for k < 32, 32 for k >= 32.
  - Stage 3, k = 13 -> addr 8.
  - oDONE one cycle after the final valid.
- Back-pressure: iRDY toggles 1-0-1 every cycle -> oADDR holds while low; still exactly 256 valids in order; no duplicates or skips; stall on the last address delays FLUSH.
- Start rules: iSTART held high throughout a run and during DONE -> ignored; a new run begins only from IDLE; back-to-back runs give 2 × 256 valids.
- Mid-run reset: iRESET at stage 2, k = 17 -> next cycle oVALID = oBUSY = 0, no oDONE; a fresh iSTART restarts at stage 0, addr 0.
- With FHT_ROM_ADDR_BITREV_EN: stage 3, k = 13 (masked 6'b001000) -> oADDR = 6'b000100 = 4; stage 0 still addr 0.

Source files
------------

// File: rtl/fht_pkg.sv
// -----------------------------------------------------------------------------
// fht_pkg
//   Shared definitions for the FHT twiddle-ROM address sequencer:
//   - fht_state_e : sequencer FSM encoding (IDLE=0, RUN=1, FLUSH=2, DONE=3)
//   - fht_mask    : per-stage address mask (keeps the top s of a_bit bits)
//   - fht_bitrev  : bit reversal over the low a_bit bits
//   Both helpers work on a FHT_MAX_W-bit container; callers cast the result
//   down to their own address width.
// -----------------------------------------------------------------------------
package fht_pkg;

    localparam int unsigned FHT_MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } fht_state_e;

    // Bits [a_bit-1 : a_bit-s] set, everything else clear. s = 0 gives an
    // all-zero mask, s = a_bit gives the full address.
    function automatic logic [FHT_MAX_W-1:0] fht_mask(input int unsigned a_bit,
                                                      input int unsigned s);
        logic [FHT_MAX_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < FHT_MAX_W; i++) begin
            if ((i < a_bit) && (i + s >= a_bit)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic [FHT_MAX_W-1:0] fht_bitrev(input logic [FHT_MAX_W-1:0] v,
                                                        input int unsigned          a_bit);
        logic [FHT_MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < FHT_MAX_W; i++) begin
            if (i < a_bit) begin
                r[i] = v[a_bit-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fht_addr_cnt.sv
// -----------------------------------------------------------------------------
// fht_addr_cnt
//   Butterfly index (k) / stage counter for the FHT ROM address sequencer.
//   k counts 0..2^A_BIT-1; on wrap the stage advances. After the final
//   (stage STAGES-1, k max) step both counters return to zero.
//
//   Ports:
//     iCLK    in   clock
//     iRESET  in   asynchronous active-high reset
//     iCLR    in   synchronous clear of k and stage (has priority over iEN)
//     iEN     in   advance one butterfly
//     oK      out  butterfly index k
//     oSTAGE  out  stage index
//     oLAST   out  counters sit on the last (stage, k) of the transform
// -----------------------------------------------------------------------------
module fht_addr_cnt #(
    parameter int unsigned A_BIT  = 6,
    parameter int unsigned STAGES = 4,
    parameter int unsigned S_BIT  = 2
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iCLR,
    input  logic             iEN,
    output logic [A_BIT-1:0] oK,
    output logic [S_BIT-1:0] oSTAGE,
    output logic             oLAST
);

    logic [A_BIT-1:0] k_q, k_d;
    logic [S_BIT-1:0] stage_q, stage_d;
    logic             k_max;
    logic             last;

    assign k_max = (k_q == '1);
    assign last  = k_max && (stage_q == S_BIT'(STAGES - 1));

    always_comb begin
        k_d     = k_q;
        stage_d = stage_q;
        if (iCLR) begin
            k_d     = '0;
            stage_d = '0;
        end else if (iEN) begin
            // k wraps naturally at 2^A_BIT
            k_d = k_q + A_BIT'(1);
            if (k_max) begin
                stage_d = last ? '0 : stage_q + S_BIT'(1);
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            k_q     <= '0;
            stage_q <= '0;
        end else begin
            k_q     <= k_d;
            stage_q <= stage_d;
        end
    end

    assign oK     = k_q;
    assign oSTAGE = stage_q;
    assign oLAST  = last;

endmodule

// File: rtl/fht_rom_addr_gen.sv
// -----------------------------------------------------------------------------
// fht_rom_addr_gen
//   Address sequencer for the FHT twiddle ROM. For every transform it sweeps
//   all STAGES stages x 2^A_BIT butterflies, presenting oADDR combinationally
//   from the counters. oVALID / oSTAGE / oST_ZERO are registered so they line
//   up with the ROM's one-cycle registered sin/cos output.
//
//   Optional build macro: FHT_ROM_ADDR_BITREV_EN
//     defined   -> oADDR is the bit-reversed masked address (bit-reversed ROM)
//     undefined -> natural order, oADDR = k & MASK(stage)
//
//   Ports:
//     iCLK      in   clock
//     iRESET    in   asynchronous active-high reset
//     iSTART    in   start pulse, sampled only in IDLE
//     iRDY      in   datapath ready; address advances only while high
//     oADDR     out  ROM address
//     oST_ZERO  out  stage-zero flag aligned with ROM q
//     oSTAGE    out  stage index of the current ROM q
//     oVALID    out  ROM q valid this cycle
//     oBUSY     out  high from accepted start until done
//     oDONE     out  single-cycle pulse after the last valid
// -----------------------------------------------------------------------------
module fht_rom_addr_gen
    import fht_pkg::*;
#(
    parameter  int unsigned A_BIT  = 6,
    parameter  int unsigned STAGES = 4,
    localparam int unsigned S_BIT  = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iSTART,
    input  logic             iRDY,
    output logic [A_BIT-1:0] oADDR,
    output logic             oST_ZERO,
    output logic [S_BIT-1:0] oSTAGE,
    output logic             oVALID,
    output logic             oBUSY,
    output logic             oDONE
);

    fht_state_e       state_q, state_d;
    logic             valid_q, valid_d;
    logic [S_BIT-1:0] stage_q, stage_d;
    logic             st_zero_q, st_zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic [A_BIT-1:0] cnt_k;
    logic [S_BIT-1:0] cnt_stage;
    logic             cnt_last;
    logic [A_BIT-1:0] addr_nat;

    fht_addr_cnt #(
        .A_BIT  (A_BIT),
        .STAGES (STAGES),
        .S_BIT  (S_BIT)
    ) u_cnt (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .iCLR   (cnt_clr),
        .iEN    (cnt_en),
        .oK     (cnt_k),
        .oSTAGE (cnt_stage),
        .oLAST  (cnt_last)
    );

    always_comb begin
        state_d   = state_q;
        valid_d   = 1'b0;
        stage_d   = '0;
        st_zero_d = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iSTART) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            ST_RUN: begin
                // Address is accepted this cycle; its q appears next cycle,
                // so stage/st_zero are captured with the valid.
                if (iRDY) begin
                    cnt_en    = 1'b1;
                    valid_d   = 1'b1;
                    stage_d   = cnt_stage;
                    st_zero_d = (cnt_stage == '0);
                    if (cnt_last) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            stage_q   <= '0;
            st_zero_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            stage_q   <= stage_d;
            st_zero_q <= st_zero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign addr_nat = A_BIT'(fht_mask(A_BIT, 32'(cnt_stage)) & 32'(cnt_k));

`ifdef FHT_ROM_ADDR_BITREV_EN
    assign oADDR = A_BIT'(fht_bitrev(32'(addr_nat), A_BIT));
`else
    assign oADDR = addr_nat;
`endif

    assign oST_ZERO = st_zero_q;
    assign oSTAGE   = stage_q;
    assign oVALID   = valid_q;
    assign oBUSY    = busy_q;
    assign oDONE    = done_q;

endmodule
